free_list: RTL and testbench

- Physical-register free list for the R10K-style rename stage.
- Supplies up to two free physical tags per cycle to dispatch (fl_pr0/fl_pr1, consumed by ROB and map table).
- Reclaims up to two tags per cycle from ROB retire (rob_retire_tag_a/b, rob_retire_num).
- Keeps a retire-side head pointer so a pipeline flush returns every speculatively allocated tag in one cycle.

---
 rtl/free_list.sv | 69 ++++++
 tb/tb_free_list.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// rtl/free_list.sv - R10K-style physical register free list
// Dual allocate / dual reclaim circular buffer with a retire head for single-cycle flush recovery.
module free_list #(
   parameter int PR_NUM   = 128,
   parameter int ARCH_NUM = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [1:0]                    id_dispatch_num,
   input  logic [1:0]                    rob_retire_num,
   input  logic [$clog2(PR_NUM)-1:0]     rob_retire_tag_a,
   input  logic [$clog2(PR_NUM)-1:0]     rob_retire_tag_b,
   input  logic                          flush,
   output logic [$clog2(PR_NUM)-1:0]     fl_pr0,
   output logic [$clog2(PR_NUM)-1:0]     fl_pr1,
   output logic [1:0]                    fl_cap,
   output logic [$clog2(PR_NUM+1)-1:0]   fl_count
);

   localparam int TW       = $clog2(PR_NUM);
   localparam int CW       = $clog2(PR_NUM + 1);
   localparam int FREE_NUM = PR_NUM - ARCH_NUM;

   logic [TW-1:0] mem [PR_NUM];
   logic [TW-1:0] head, tail, rhead;
   logic [CW-1:0] count;

   logic [1:0]    req, ret, cap, alloc;
   logic [TW-1:0] head_p1, tail_p1;

   // 2'b11 on either request port behaves as 2
   assign req     = (id_dispatch_num == 2'b11) ? 2'd2 : id_dispatch_num;
   assign ret     = (rob_retire_num == 2'b11) ? 2'd2 : rob_retire_num;
   assign cap     = (count >= CW'(2)) ? 2'd2 : count[1:0];
   assign alloc   = (req < cap) ? req : cap;
   assign head_p1 = head + TW'(1);
   assign tail_p1 = tail + TW'(1);

   assign fl_pr0   = (count == '0) ? '1 : mem[head];
   assign fl_pr1   = (count < CW'(2)) ? '1 : mem[head_p1];
   assign fl_cap   = cap;
   assign fl_count = count;

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < PR_NUM; i++) begin
            mem[i] <= (i < FREE_NUM) ? TW'(ARCH_NUM + i) : '0;
         end
         head  <= '0;
         rhead <= '0;
         tail  <= TW'(FREE_NUM);
         count <= CW'(FREE_NUM);
      end else begin
         if (ret != 2'd0) mem[tail]    <= rob_retire_tag_a;
         if (ret == 2'd2) mem[tail_p1] <= rob_retire_tag_b;
         tail  <= tail + TW'(ret);
         rhead <= rhead + TW'(ret);
         // Flush rewinds head to the committed point; tags between rhead and head are still stored
         if (flush) begin
            head  <= rhead + TW'(ret);
            count <= CW'(FREE_NUM);
         end else begin
            head  <= head + TW'(alloc);
            count <= count - CW'(alloc) + CW'(ret);
         end
      end
   end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - self-checking bench for free_list
// Queue-based reference model: free tags in order, plus in-flight allocations oldest first.
module tb_free_list;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] id_dispatch_num = 2'd0;
   logic [1:0] rob_retire_num = 2'd0;
   logic [6:0] rob_retire_tag_a = 7'd0;
   logic [6:0] rob_retire_tag_b = 7'd0;
   logic       flush = 1'b0;
   logic [6:0] fl_pr0, fl_pr1;
   logic [1:0] fl_cap;
   logic [7:0] fl_count;

   free_list dut (
      .clock            (clock),
      .reset            (reset),
      .id_dispatch_num  (id_dispatch_num),
      .rob_retire_num   (rob_retire_num),
      .rob_retire_tag_a (rob_retire_tag_a),
      .rob_retire_tag_b (rob_retire_tag_b),
      .flush            (flush),
      .fl_pr0           (fl_pr0),
      .fl_pr1           (fl_pr1),
      .fl_cap           (fl_cap),
      .fl_count         (fl_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] fq[$];
   logic [6:0] aq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      aq.delete();
      for (int i = 0; i < 96; i++) fq.push_back(7'(32 + i));
   endtask

   task automatic model_update(input logic [1:0] d, input logic [1:0] r,
                               input logic [6:0] ta, input logic [6:0] tb, input logic f);
      int req, rr, a;
      req = (d == 2'd3) ? 2 : int'(d);
      rr  = (r == 2'd3) ? 2 : int'(r);
      a   = (req > fq.size()) ? fq.size() : req;
      if (f) a = 0;
      for (int i = 0; i < a; i++) aq.push_back(fq.pop_front());
      for (int i = 0; i < rr; i++) void'(aq.pop_front());
      if (rr >= 1) fq.push_back(ta);
      if (rr == 2) fq.push_back(tb);
      if (f) begin
         while (aq.size() > 0) fq.push_front(aq.pop_back());
      end
   endtask

   task automatic check_all(input string ph);
      logic [6:0] e0, e1, inv;
      e0  = (fq.size() > 0) ? fq[0] : 7'h7f;
      e1  = (fq.size() > 1) ? fq[1] : 7'h7f;
      inv = dut.tail - dut.rhead;
      check({ph, "_pr0"}, 32'(fl_pr0), 32'(e0));
      check({ph, "_pr1"}, 32'(fl_pr1), 32'(e1));
      check({ph, "_cap"}, 32'(fl_cap), (fq.size() > 2) ? 32'd2 : 32'(fq.size()));
      check({ph, "_count"}, 32'(fl_count), 32'(fq.size()));
      check({ph, "_inv"}, 32'(inv), 32'd96);
   endtask

   task automatic cycle(input string ph, input logic [1:0] d, input logic [1:0] r,
                        input logic [6:0] ta, input logic [6:0] tb, input logic f);
      id_dispatch_num  = d;
      rob_retire_num   = r;
      rob_retire_tag_a = ta;
      rob_retire_tag_b = tb;
      flush            = f;
      @(posedge clock);
      model_update(d, r, ta, tb, f);
      #1;
      check_all(ph);
   endtask

   task automatic do_reset(input int n, input logic [1:0] d);
      reset = 1'b0;
      id_dispatch_num = d;
      rob_retire_num = 2'd0;
      flush = 1'b0;
      repeat (n) @(posedge clock);
      #1;
      reset = 1'b1;
      model_reset();
      check("rst_pr0", 32'(fl_pr0), 32'd32);
      check("rst_pr1", 32'(fl_pr1), 32'd33);
      check("rst_cap", 32'(fl_cap), 32'd2);
      check("rst_count", 32'(fl_count), 32'd96);
      check_all("rst");
   endtask

   initial begin
      int rmax, rr;
      logic [1:0] d, r;
      logic [6:0] ta, tb;
      logic f;

      // Reset values
      do_reset(2, 2'd0);

      // Drain to empty: tags leave in ascending order
      for (int k = 0; k < 48; k++) begin
         check("drain_order0", 32'(fl_pr0), 32'(32 + 2 * k));
         check("drain_order1", 32'(fl_pr1), 32'(33 + 2 * k));
         cycle("drain", 2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
      end
      check("empty_cap", 32'(fl_cap), 32'd0);
      check("empty_pr0", 32'(fl_pr0), 32'h7f);
      check("empty_pr1", 32'(fl_pr1), 32'h7f);
      check("empty_count", 32'(fl_count), 32'd0);
      cycle("empty_disp", 2'd2, 2'd0, 7'd0, 7'd0, 1'b0);

      // Retire while empty: no same-cycle bypass
      check("nobypass_cap", 32'(fl_cap), 32'd0);
      cycle("ret_empty", 2'd2, 2'd2, 7'd5, 7'd9, 1'b0);
      check("ret_empty_pr0", 32'(fl_pr0), 32'd5);
      check("ret_empty_pr1", 32'(fl_pr1), 32'd9);
      check("ret_empty_count", 32'(fl_count), 32'd2);

      // Flush recovery with a same-cycle retire
      do_reset(1, 2'd0);
      repeat (3) cycle("pre_flush", 2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
      check("pre_flush_count", 32'(fl_count), 32'd90);
      cycle("flush", 2'd1, 2'd1, 7'd3, 7'd0, 1'b1);
      check("flush_pr0", 32'(fl_pr0), 32'd33);
      check("flush_pr1", 32'(fl_pr1), 32'd34);
      check("flush_count", 32'(fl_count), 32'd96);
      check("flush_entry96", 32'(dut.mem[96]), 32'd3);

      // Wrap-around: steady dispatch-2 / retire-2 of the oldest in-flight tags
      cycle("wrap_prime", 2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
      for (int k = 0; k < 200; k++) begin
         cycle("wrap", 2'd2, 2'd2, aq[0], aq[1], 1'b0);
      end
      check("wrap_count", 32'(fl_count), 32'd94);

      // Random mix with occasional flushes
      for (int k = 0; k < 400; k++) begin
         d    = 2'($urandom_range(0, 3));
         rmax = (aq.size() > 2) ? 2 : aq.size();
         rr   = $urandom_range(0, rmax);
         r    = (rr == 2 && $urandom_range(0, 1) == 1) ? 2'd3 : 2'(rr);
         ta   = (rr >= 1) ? aq[0] : 7'($urandom);
         tb   = (rr == 2) ? aq[1] : 7'($urandom);
         f    = ($urandom_range(0, 31) == 0);
         cycle("rand", d, r, ta, tb, f);
      end

      // Clamp: request of 3 with one tag left
      do_reset(1, 2'd0);
      repeat (47) cycle("clamp_fill", 2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
      cycle("clamp_one", 2'd1, 2'd0, 7'd0, 7'd0, 1'b0);
      check("clamp_count1", 32'(fl_count), 32'd1);
      check("clamp_cap1", 32'(fl_cap), 32'd1);
      cycle("clamp", 2'd3, 2'd0, 7'd0, 7'd0, 1'b0);
      check("clamp_count0", 32'(fl_count), 32'd0);
      check("clamp_pr0", 32'(fl_pr0), 32'h7f);

      // Reset mid-stream while dispatch is requesting
      do_reset(1, 2'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
